reg4_serial_tx: RTL

Parallel-to-serial transmitter for the 4-bit register path. It captures a 4-bit word from the register output with a valid/ready handshake. It then shifts the word out on a single line as a framed serial stream: start bit, 4 data bits MSB first, optional even parity, and a stop bit. It is the transmitting end of the register link and feeds the serial receiver/deserializer on the display/game side.

---
 rtl/reg4_serial_tx_if.sv | 38 +++
 rtl/reg4_serial_tx.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/reg4_serial_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : reg4_serial_tx_if
// Description : Load handshake and serial-line bundle for reg4_serial_tx.
//               The master side offers a 4-bit word with load. The slave side
//               returns ready and drives the framed serial line together with
//               the busy and done status.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg4_serial_tx_if;
  logic [3:0] D;      // word offered for transmission
  logic       load;   // request to transmit D
  logic       ready;  // a load is accepted this cycle
  logic       tx;     // serial line, idles high
  logic       busy;   // frame in progress
  logic       done;   // one-cycle pulse after the stop bit

  // Producer of words / consumer of the line
  modport master (
    output D,
    output load,
    input  ready,
    input  tx,
    input  busy,
    input  done
  );

  // Transmitter
  modport slave (
    input  D,
    input  load,
    output ready,
    output tx,
    output busy,
    output done
  );
endinterface
`default_nettype wire

// File: rtl/reg4_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : reg4_serial_tx
// Description : Parallel-to-serial transmitter for the 4-bit register path.
//               It accepts a word on a load handshake and sends it as a frame
//               of start bit, D3..D0 (MSB first), an optional even parity bit
//               and a stop bit. Each bit lasts DIV clock cycles. tx, busy and
//               done are registered. ready decodes the idle state.
// Revision    : 1.0 - initial release
// ============================================================================
module reg4_serial_tx #(
  parameter int DIV       = 4,     // clock cycles per serial bit, 1..255
  parameter bit PARITY_EN = 1'b1   // 1: even parity bit follows D0
) (
  input wire               C,      // system clock
  input wire               clr_n,  // asynchronous active-low reset
  reg4_serial_tx_if.slave  bus
);

  // Reload value for the bit timer. The bit ends when the timer reaches zero,
  // so DIV-1 gives DIV cycles per bit, and DIV=1 gives one cycle per bit.
  localparam logic [7:0] c_div_m1 = 8'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t     state_q,  state_d;
  logic [3:0] shift_q,  shift_d;   // latched word; the MSB is the current data bit
  logic [1:0] bitcnt_q, bitcnt_d;  // data bits already completed
  logic [7:0] timer_q,  timer_d;   // cycles left in the current bit, minus one
  logic       par_q,    par_d;     // even parity of the latched word
  logic       tx_q,     tx_d;
  logic       busy_q,   busy_d;
  logic       done_q,   done_d;

  logic       w_bit_end;           // last cycle of the current bit

  assign w_bit_end = (timer_q == 8'd0);

  // State register and registered outputs. While reset is held the line stays
  // high and no frame can start, so a load during reset is dropped.
  always_ff @(posedge C or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= S_IDLE;
      shift_q  <= 4'd0;
      bitcnt_q <= 2'd0;
      timer_q  <= 8'd0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      timer_q  <= timer_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic. tx_d is the line value for the cycle after the edge.
  // Because the line is registered, each branch computes the bit that the
  // next state will present. done_d defaults low, so done is a single pulse.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    timer_d  = timer_q;
    par_d    = par_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        // The done cycle is also an idle cycle. A load here starts the next
        // frame, and its start bit appears on the following cycle.
        if (bus.load) begin
          shift_d  = bus.D;
          par_d    = ^bus.D;
          bitcnt_d = 2'd0;
          timer_d  = c_div_m1;
          state_d  = S_START;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          timer_d = c_div_m1;
          state_d = S_DATA;
          tx_d    = shift_q[3];
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          timer_d = c_div_m1;
          shift_d = {shift_q[2:0], 1'b0};
          if (bitcnt_q == 2'd3) begin
            bitcnt_d = 2'd0;
            if (PARITY_EN) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            // After the shift, the next data bit is the current bit 2.
            bitcnt_d = bitcnt_q + 2'd1;
            tx_d     = shift_q[2];
          end
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end

      S_PARITY: begin
        if (w_bit_end) begin
          timer_d = c_div_m1;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          timer_d = c_div_m1;
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Output mapping onto the interface
  assign bus.ready = (state_q == S_IDLE);
  assign bus.tx    = tx_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
`default_nettype wire
